// File: rtl/simple_circuit_pkg.sv
// rtl/simple_circuit_pkg.sv - shared types, constants and golden function for the gate-circuit self-test
//
// Contents:
//   state_e   : sequencer states (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
//   N_VECTORS : number of input vectors walked per sweep
//   golden()  : reference function x = (a & b) | ~c of the circuit under test
package simple_circuit_pkg;

  localparam int N_VECTORS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic logic golden(input logic a, input logic b, input logic c);
    return (a & b) | ~c;
  endfunction

endpackage

// File: rtl/simple_circuit_golden.sv
// rtl/simple_circuit_golden.sv - combinational expected response for a circuit input vector
//
// Ports:
//   stim_i [2:0] : circuit inputs {C,B,A}
//   exp_o        : expected circuit output x
module simple_circuit_golden
  import simple_circuit_pkg::*;
(
  input  logic [2:0] stim_i,
  output logic       exp_o
);

  assign exp_o = golden(stim_i[0], stim_i[1], stim_i[2]);

endmodule

// File: rtl/simple_circuit_tester.sv
// rtl/simple_circuit_tester.sv - self-test sequencer sweeping all input vectors of the gate circuit
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   start      : request a sweep (accepted in IDLE or DONE only)
//   abort      : cancel a running sweep, results kept for debug
//   resp       : circuit output x
//   stim [2:0] : circuit inputs, stim[0]=A, stim[1]=B, stim[2]=C
//   busy       : sweep in progress
//   done       : sweep finished, held until next start/abort/rst
//   pass       : no vector failed (valid with done)
//   err_count  : number of failing vectors, 0..8
//   fail_map   : bit v set when vector v failed
module simple_circuit_tester
  import simple_circuit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       resp,
  output logic [2:0] stim,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_VEC    = 3'(N_VECTORS - 1);

  state_e     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] stim_q, stim_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [7:0] map_q, map_d;
  logic       exp_x;

  simple_circuit_golden u_golden (
    .stim_i (stim_q),
    .exp_o  (exp_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      map_q   <= map_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    pass_d  = pass_q;
    err_d   = err_q;
    map_d   = map_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          map_d   = '0;
          pass_d  = 1'b0;
          v_d     = '0;
          stim_d  = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // stim already carries v: it is only ever loaded on the way into DRIVE.
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        if (resp != exp_x) begin
          map_d[v_q] = 1'b1;
          err_d      = err_q + 4'd1;
        end
        if (v_q == LAST_VEC) begin
          // err_d already includes the vector sampled this cycle.
          pass_d  = (err_d == 4'd0);
          state_d = DONE;
        end else begin
          v_d     = v_q + 3'd1;
          stim_d  = v_q + 3'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start; the
    // partial results are left visible for debug.
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      stim_d  = '0;
      err_d   = err_q;
      map_d   = map_q;
    end
  end

  assign stim      = stim_q;
  assign busy      = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_map  = map_q;

endmodule

// File: tb/tb_simple_circuit_tester.sv
// tb/tb_simple_circuit_tester.sv - self-checking bench for the gate-circuit self-test sequencer
module tb_simple_circuit_tester;

  localparam int P0 = 2 + 2;  // cycles per vector at the default settle time

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp;
  logic [2:0] stim;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_map;
  logic       gold_x;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic       resp1;
  logic [2:0] stim1;
  logic       busy1, done1, pass1;
  logic [3:0] err_count1;
  logic [7:0] fail_map1;

  int mode = 0;  // 0: fault-free, 1: stuck at 0, 2: stuck at 1

  always #5 clk = ~clk;

  simple_circuit_golden u_gold  (.stim_i(stim),  .exp_o(gold_x));
  simple_circuit_golden u_gold1 (.stim_i(stim1), .exp_o(resp1));

  assign resp = (mode == 0) ? gold_x : (mode == 2);

  simple_circuit_tester dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .stim(stim), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_map(fail_map)
  );

  simple_circuit_tester #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_map(fail_map1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth table of x = (A&B)|~C indexed by {C,B,A}: ones at 0,1,2,3,7.
  logic [7:0] gold_tbl = 8'h8F;

  function automatic logic [7:0] fmap(input int n, input int md);
    logic [7:0] m = '0;
    logic r;
    for (int v = 0; v < n && v < 8; v++) begin
      r = (md == 0) ? gold_tbl[v] : (md == 2);
      if (r != gold_tbl[v]) m[v] = 1'b1;
    end
    return m;
  endfunction

  // Model: m_t is the cycle number since the accepted start.
  bit         m_run = 1'b0, m_done = 1'b0;
  int         m_t = 0;
  logic [7:0] m_map = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_done <= 1'b0; m_t <= 0; m_map <= '0;
    end else if (abort) begin
      if (m_run) m_map <= fmap((m_t - 1) / P0, mode);
      m_run <= 1'b0; m_done <= 1'b0;
    end else if (start && !m_run) begin
      m_run <= 1'b1; m_t <= 1; m_done <= 1'b0; m_map <= '0;
    end else if (m_run) begin
      if (m_t == 8 * P0) begin
        m_run <= 1'b0; m_done <= 1'b1; m_map <= fmap(8, mode);
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e_map;
    logic [3:0] e_err;
    if (chk_en) begin
      e_map = m_run ? fmap((m_t - 1) / P0, mode) : m_map;
      e_err = 4'($countones(e_map));
      chk("stim", 32'(stim), m_run ? 32'((m_t - 1) / P0) : (m_done ? 32'd7 : 32'd0));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_done && e_err == 0));
      chk("err_count", 32'(err_count), 32'(e_err));
      chk("fail_map", 32'(fail_map), 32'(e_map));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit which, inout int n);
    while (!(which ? done1 : done) && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_stim", 32'(stim), 0);
    chk("reset_done", 32'(done), 0);

    // Fault-free sweep, done at cycle 33.
    start_sweep(); n = 1;
    chk("busy_cycle1", 32'(busy), 1);
    wait_done(1'b0, n);
    chk("ff_done_cycle", n, 33);
    chk("ff_pass", 32'(pass), 1);
    chk("ff_map", 32'(fail_map), 32'h00);

    // Stuck-at-0 (restart from DONE).
    mode = 1;
    start_sweep(); n = 1;
    chk("sa0_cleared", 32'(done), 0);
    wait_done(1'b0, n);
    chk("sa0_done_cycle", n, 33);
    chk("sa0_pass", 32'(pass), 0);
    chk("sa0_err", 32'(err_count), 5);
    chk("sa0_map", 32'(fail_map), 32'h8F);

    // Stuck-at-1.
    mode = 2;
    start_sweep(); n = 1;
    wait_done(1'b0, n);
    chk("sa1_err", 32'(err_count), 3);
    chk("sa1_map", 32'(fail_map), 32'h70);

    // start and abort together in DONE: abort wins, results retained.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_done", 32'(done), 0);
    chk("sa_busy", 32'(busy), 0);
    chk("sa_map_kept", 32'(fail_map), 32'h70);

    // Abort during vector 4's settle with stuck-at-0.
    mode = 1;
    start_sweep();
    repeat (17) tick();  // cycle 18
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_stim", 32'(stim), 0);
    chk("ab_err", 32'(err_count), 4);
    chk("ab_map", 32'(fail_map), 32'h0F);
    mode = 0;
    start_sweep(); n = 1;
    wait_done(1'b0, n);
    chk("ab_rerun_cycle", n, 33);
    chk("ab_rerun_pass", 32'(pass), 1);

    // start pulsed mid-sweep is ignored.
    start_sweep(); n = 1;
    repeat (9) tick();
    start_sweep(); n = 11;
    wait_done(1'b0, n);
    chk("mid_start_cycle", n, 33);

    // Reset mid-sweep.
    mode = 1;
    start_sweep();
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_map", 32'(fail_map), 0);

    // Reset at SAMPLE of vector 7 (cycle 32).
    start_sweep();
    repeat (31) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_s7_done", 32'(done), 0);
    chk("rst_s7_err", 32'(err_count), 0);
    repeat (10) tick();
    chk("rst_s7_stays", 32'(done), 0);

    // Fault-free sweep with SETTLE_CYCLES=1: done at cycle 25.
    start1 = 1'b1; tick(); start1 = 1'b0; n = 1;
    chk("s1_busy", 32'(busy1), 1);
    wait_done(1'b1, n);
    chk("s1_done_cycle", n, 25);
    chk("s1_pass", 32'(pass1), 1);
    chk("s1_map", 32'(fail_map1), 0);
    chk("s1_stim", 32'(stim1), 7);

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
